// File: rtl/lfsr_pkg.sv
// lfsr_pkg: width limits and maximal-length tap table shared by the lfsr
package lfsr_pkg;

    localparam int MIN_W = 2;
    localparam int MAX_W = 32;

    // Tap mask for width n: bit p-1 is set for each 1-based tap position p. Unsupported widths return zero.
    function automatic logic [31:0] lfsr_taps(input int n);
        case (n)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr.sv
// lfsr: free-running Fibonacci LFSR with XNOR feedback and all-ones lockup recovery
module lfsr
    import lfsr_pkg::*;
#(
    parameter int LFSR_DW      = 7,
    parameter     LFSR_DEFAULT = 8'h00
) (
    input  logic             CLK,
    input  logic             RST_N,
    output logic [LFSR_DW:0] O_DATA
);

    localparam int N = LFSR_DW + 1;

    if (N < MIN_W || N > MAX_W) begin : g_bad_width
        $error("lfsr: register width %0d outside %0d..%0d", N, MIN_W, MAX_W);
    end

    localparam logic [N-1:0] TAPS     = N'(lfsr_taps(N));
    localparam logic [N-1:0] SEED_RAW = N'(LFSR_DEFAULT);
    // All-ones is the XNOR lockup state, so a seed of all-ones is replaced by all-zeros
    localparam logic [N-1:0] SEED     = &SEED_RAW ? '0 : SEED_RAW;

    logic [N-1:0] q;
    logic         fb;
    logic [N-1:0] nxt;

    // Feedback is the XNOR of the tapped bits; all-ones is steered back to zero so the register never stalls
    always_comb begin
        fb  = ~^(q & TAPS);
        nxt = &q ? '0 : {q[N-2:0], fb};
    end

    // State register: loads the seed while reset is low, otherwise advances every cycle
    always_ff @(posedge CLK) begin
        if (!RST_N) q <= SEED;
        else        q <= nxt;
    end

    assign O_DATA = q;

endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: directed checks of the lfsr sequences, reset behaviour, lockup recovery and full periods
module tb_lfsr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  o_ff;
    logic [1:0]  o_frc;
    logic [16:0] outs [2:16];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar w = 2; w <= 16; w++) begin : g_w
        logic [w-1:0] d;
        lfsr #(.LFSR_DW(w - 1), .LFSR_DEFAULT(0)) u_lfsr (.CLK(clk), .RST_N(rst_n), .O_DATA(d));
        assign outs[w] = 17'(d);
    end

    lfsr #(.LFSR_DW(7), .LFSR_DEFAULT(8'hFF)) u_ff (.CLK(clk), .RST_N(rst_n), .O_DATA(o_ff));
    lfsr #(.LFSR_DW(1), .LFSR_DEFAULT(0))     u_frc (.CLK(clk), .RST_N(rst_n), .O_DATA(o_frc));

    logic [1:0] exp2 [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
    logic [7:0] exp8 [8] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A};

    bit seen [2:16][65536];
    int first_rep [2:16];
    int distinct [2:16];
    int lock_hits [2:16];

    // Pulse reset for two edges and return on the negedge where the seed is visible, before the first shift
    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk) rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (outs[8] !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_hold_n8 got %h want %h", outs[8], 17'h0);
        end
        vectors++;
        if (outs[2] !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_hold_n2 got %h want %h", outs[2], 17'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs[8] !== 17'h1) begin
            miscompares++;
            $display("FAIL first_shift_n8 got %h want %h", outs[8], 17'h1);
        end
    endtask

    task automatic test_n2_sequence();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            vectors++;
            if (outs[2] !== 17'(exp2[i])) begin
                miscompares++;
                $display("FAIL n2_seq[%0d] got %h want %h", i, outs[2], exp2[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_n8_sequence();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (outs[8] !== 17'(exp8[i])) begin
                miscompares++;
                $display("FAIL n8_seq[%0d] got %h want %h", i, outs[8], exp8[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_seed_ones();
        do_reset();
        vectors++;
        if (o_ff !== 8'h00) begin
            miscompares++;
            $display("FAIL seed_ones_reset got %h want %h", o_ff, 8'h00);
        end
        @(negedge clk);
        vectors++;
        if (o_ff !== 8'h01) begin
            miscompares++;
            $display("FAIL seed_ones_shift got %h want %h", o_ff, 8'h01);
        end
    endtask

    task automatic test_lockup_recovery();
        @(negedge clk);
        force u_frc.q = 2'b11;
        #1;
        release u_frc.q;
        vectors++;
        if (o_frc !== 2'b11) begin
            miscompares++;
            $display("FAIL lockup_forced got %h want %h", o_frc, 2'b11);
        end
        @(negedge clk);
        vectors++;
        if (o_frc !== 2'b00) begin
            miscompares++;
            $display("FAIL lockup_recover got %h want %h", o_frc, 2'b00);
        end
        @(negedge clk);
        vectors++;
        if (o_frc !== 2'b01) begin
            miscompares++;
            $display("FAIL lockup_resume got %h want %h", o_frc, 2'b01);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int c = 0; c < 37; c++) begin
            if (c < 8) begin
                vectors++;
                if (outs[8] !== 17'(exp8[c])) begin
                    miscompares++;
                    $display("FAIL mid_pre[%0d] got %h want %h", c, outs[8], exp8[c]);
                end
            end
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (outs[8] !== 17'h0) begin
            miscompares++;
            $display("FAIL mid_reset_seed got %h want %h", outs[8], 17'h0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (outs[8] !== 17'(exp8[c])) begin
                miscompares++;
                $display("FAIL mid_post[%0d] got %h want %h", c, outs[8], exp8[c]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_full_period();
        for (int n = 2; n <= 16; n++) begin
            first_rep[n] = -1;
            distinct[n]  = 0;
            lock_hits[n] = 0;
            for (int i = 0; i < 65536; i++) seen[n][i] = 1'b0;
        end
        do_reset();
        for (int c = 0; c < 65536; c++) begin
            for (int n = 2; n <= 16; n++) begin
                if (c < (1 << n)) begin
                    int v;
                    v = int'(outs[n]);
                    if (c > 0 && v == 0 && first_rep[n] < 0) first_rep[n] = c;
                    if (v == (1 << n) - 1) lock_hits[n]++;
                    if (c < (1 << n) - 1 && !seen[n][v]) begin
                        seen[n][v] = 1'b1;
                        distinct[n]++;
                    end
                end
            end
            @(negedge clk);
        end
        for (int n = 2; n <= 16; n++) begin
            vectors++;
            if (first_rep[n] !== (1 << n) - 1) begin
                miscompares++;
                $display("FAIL period_n%0d got %0d want %0d", n, first_rep[n], (1 << n) - 1);
            end
            vectors++;
            if (distinct[n] !== (1 << n) - 1) begin
                miscompares++;
                $display("FAIL distinct_n%0d got %0d want %0d", n, distinct[n], (1 << n) - 1);
            end
            vectors++;
            if (lock_hits[n] !== 0) begin
                miscompares++;
                $display("FAIL lockup_seen_n%0d got %0d want %0d", n, lock_hits[n], 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_n2_sequence();
        test_n8_sequence();
        test_seed_ones();
        test_lockup_recovery();
        test_mid_reset();
        test_full_period();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
